// File: rtl/chess_clock_ctrl.sv
// Multi-player chess game clock: per-player countdown, Fischer increment, flag and low-time
// detection, registered BCD mm:ss for the HEX driver. Optional US delay via `DELAY_MODE_EN.
module chess_clock_ctrl #(
  parameter int unsigned CLK_FREQ_HZ = 50_000_000,
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned PW          = 2,
  parameter int unsigned MODE_BITS   = 2,
  parameter int unsigned LOW_TIME_S  = 10
`ifdef DELAY_MODE_EN
  , parameter int unsigned DELAY_S   = 3
`endif
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
  input  logic [PW-1:0]        first_player,
  input  logic [MODE_BITS-1:0] mode_sel,
  input  logic                 move_done,
  input  logic                 pause,
  output logic [PW-1:0]        active_player,
  output logic [12:0]          time_left,
  output logic [15:0]          disp_bcd,
  output logic                 running,
  output logic                 low_time,
  output logic                 time_up,
  output logic [PW-1:0]        flagged_player
);

  localparam int unsigned TW    = 13;
  localparam int unsigned CW    = (CLK_FREQ_HZ > 1) ? $clog2(CLK_FREQ_HZ) : 1;
  localparam int unsigned NSLOT = 2 ** PW;
  localparam logic [CW-1:0] CNT_MAX  = CW'(CLK_FREQ_HZ - 1);
  localparam logic [TW-1:0] TIME_MAX = TW'(5999);
  localparam logic [PW-1:0] LAST_P   = PW'(NUM_PLAYERS - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_PAUSED, S_FLAGGED} state_t;

  state_t        r_state;
  state_t        w_next;
  logic [TW-1:0] r_time [NSLOT];
  logic [PW-1:0] r_active;
  logic [PW-1:0] r_flagged;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_inc;
  logic [15:0]   r_disp;

  logic [TW-1:0] w_base;
  logic [2:0]    w_inc_sel;
  logic [PW-1:0] w_fp;
  logic [TW-1:0] w_cur;
  logic [TW-1:0] w_dec;
  logic [13:0]   w_sum;
  logic [TW-1:0] w_add;
  logic          w_wrap;
  logic          w_dec_en;
  logic          w_flag;
  logic          w_move;
  logic          w_running;
  logic          w_time_up;

  // Time-control table; anything above 3 behaves as 10+5.
  always_comb begin
    w_base    = TW'(600);
    w_inc_sel = 3'd5;
    case (32'(mode_sel))
      0:       begin w_base = TW'(60);  w_inc_sel = 3'd0; end
      1:       begin w_base = TW'(180); w_inc_sel = 3'd2; end
      2:       begin w_base = TW'(300); w_inc_sel = 3'd3; end
      default: ;
    endcase
  end

  assign w_fp   = (first_player > LAST_P) ? '0 : first_player;
  assign w_cur  = r_time[r_active];
  assign w_wrap = (r_state == S_RUN) && (r_cnt == CNT_MAX);

`ifdef DELAY_MODE_EN
  localparam int unsigned DW = (DELAY_S > 0) ? $clog2(DELAY_S + 1) : 1;
  logic [DW-1:0] r_delay;

  assign w_dec_en = w_wrap && (r_delay == DW'(DELAY_S));

  // Grace-second counter: restarts each turn, saturates once the delay is used up.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                    r_delay <= '0;
    else if (start || w_move)     r_delay <= '0;
    else if (w_wrap && !w_dec_en) r_delay <= r_delay + DW'(1);
  end
`else
  assign w_dec_en = w_wrap;
`endif

  // Decrement first; a move landing on the flagging tick is dropped.
  assign w_dec  = (w_dec_en && (w_cur != '0)) ? w_cur - TW'(1) : w_cur;
  assign w_flag = w_dec_en && (w_dec == '0);
  assign w_move = (r_state == S_RUN) && move_done && !start && !w_flag;
  assign w_sum  = 14'(w_dec) + 14'(r_inc);
  assign w_add  = (w_sum > 14'(TIME_MAX)) ? TIME_MAX : TW'(w_sum);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    if (start) begin
      w_next = S_RUN;
    end else begin
      case (r_state)
        S_RUN: begin
          if (w_flag)     w_next = S_FLAGGED;
          else if (pause) w_next = S_PAUSED;
        end
        S_PAUSED: if (!pause) w_next = S_RUN;
        default: ;
      endcase
    end
  end

  always_comb begin
    w_running = 1'b0;
    w_time_up = 1'b0;
    case (r_state)
      S_RUN:     w_running = 1'b1;
      S_FLAGGED: w_time_up = 1'b1;
      default: ;
    endcase
  end

  // Per-player times, turn rotation and the one-second tick counter.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned p = 0; p < NSLOT; p++) r_time[PW'(p)] <= '0;
      r_active  <= '0;
      r_flagged <= '0;
      r_cnt     <= '0;
      r_inc     <= '0;
    end else if (start) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) r_time[PW'(p)] <= w_base;
      r_active  <= w_fp;
      r_flagged <= '0;
      r_cnt     <= '0;
      r_inc     <= w_inc_sel;
    end else if (r_state == S_RUN) begin
      if (w_move) begin
        r_time[r_active] <= w_add;
        r_active         <= (r_active == LAST_P) ? '0 : r_active + PW'(1);
        r_cnt            <= '0;
      end else begin
        r_time[r_active] <= w_dec;
        r_cnt            <= w_wrap ? '0 : r_cnt + CW'(1);
        if (w_flag) r_flagged <= r_active;
      end
    end
  end

  // Binary 0..99 to two BCD digits via reciprocal multiply (exact over this range).
  function automatic logic [7:0] bin2bcd7(input logic [6:0] v);
    logic [14:0] prod;
    logic [3:0]  tens;
    prod = 15'(v) * 15'(205);
    tens = 4'(prod >> 11);
    return {tens, 4'(v - 7'(tens) * 7'(10))};
  endfunction

  logic [27:0] w_prod;
  logic [6:0]  w_min;
  logic [5:0]  w_sec;

  // 17477/2^20 approximates 1/60 closely enough for floor() to be exact up to 5999.
  assign w_prod = 28'(time_left) * 28'(17477);
  assign w_min  = 7'(w_prod >> 20);
  assign w_sec  = 6'(time_left - 13'(w_min) * 13'(60));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) r_disp <= '0;
    else       r_disp <= {bin2bcd7(w_min), bin2bcd7(7'(w_sec))};
  end

  assign active_player  = r_active;
  assign time_left      = w_cur;
  assign disp_bcd       = r_disp;
  assign running        = w_running;
  assign time_up        = w_time_up;
  assign low_time       = w_running && (w_cur <= TW'(LOW_TIME_S));
  assign flagged_player = r_flagged;

endmodule

// File: doc/chess_clock_ctrl.md
Name: chess_clock_ctrl

Overview:
- Parametrised multi-player chess game clock, successor to the fixed two-player hex countdown.
- Holds a per-player remaining-time register and counts down the active player once per second.
- Applies a Fischer increment on each completed move and rotates the turn.
- Flags time-out and a low-time warning, and presents the active player's time as BCD mm:ss for the HEX display driver.
- Sits in the CLOCK_50 domain between the board/UART move logic and the seven-segment decoder.

Parameters:
- CLK_FREQ_HZ, 50_000_000: clk cycles per second tick.
- NUM_PLAYERS, 2: number of players, legal range 2..4.
- PW, 2: player index width; must satisfy 2^PW >= NUM_PLAYERS.
- MODE_BITS, 2: width of mode_sel.
- LOW_TIME_S, 10: low-time warning threshold, in seconds.
- DELAY_S, 3: per-turn grace seconds; used only with DELAY_MODE_EN.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle pulse; loads all clocks from mode_sel and begins play.
- first_player  in  PW  player who moves first; sampled on start.
- mode_sel  in  MODE_BITS  time control; sampled on start only.
- move_done  in  1  single-cycle pulse; active player has completed a move.
- pause  in  1  level; freezes counting while high.
- active_player  out  PW  player currently on move.
- time_left  out  13  remaining seconds of active_player, range 0..5999.
- disp_bcd  out  16  BCD {min tens, min ones, sec tens, sec ones} of time_left.
- running  out  1  high in RUN.
- low_time  out  1  high when running and time_left <= LOW_TIME_S.
- time_up  out  1  high in FLAGGED.
- flagged_player  out  PW  player whose time expired; valid while time_up.

Behaviour:
- Mode table (base s / increment s): 0 = 60/0, 1 = 180/2, 2 = 300/3, 3 = 600/5. Modes above 3 (wider MODE_BITS) map to mode 3.
- Reset (async): state IDLE; all player times 0; tick counter 0; active_player 0; all outputs 0.
- States: IDLE, RUN, PAUSED, FLAGGED.
  - IDLE -start-> RUN: load every player with the base time; active_player = first_player (values >= NUM_PLAYERS map to 0); tick counter cleared.
  - RUN -pause high-> PAUSED. PAUSED -pause low-> RUN. The tick counter holds while PAUSED.
  - RUN -active time reaches 0-> FLAGGED: time_up = 1, flagged_player = active_player. Counting stops.
  - start in any state except IDLE: full reload, same as from IDLE, including from FLAGGED. This is the restart path.
- Tick: a counter of 0..CLK_FREQ_HZ-1 counts only in RUN. On wrap, the active player's time is decremented by 1, saturating at 0.
- move_done in RUN:
  - Add the increment to the active player's time, saturating at 5999.
  - Set active_player = (active_player + 1) mod NUM_PLAYERS.
  - Clear the tick counter, so each turn starts on a fresh second.
- move_done in IDLE, PAUSED or FLAGGED is ignored.
- Tick wrap and move_done in the same cycle:
  - Apply the decrement first.
  - If the result is 0, go to FLAGGED and drop move_done.
  - Otherwise apply the increment and rotate the turn.
- start and move_done in the same cycle: start wins.
- Latency:
  - State, time registers and active_player update on the cycle after the event.
  - time_left tracks the registered active time with no extra latency.
  - disp_bcd lags time_left by exactly 1 cycle; it is a registered binary-to-BCD conversion and must be divider-free.
- time_left is shown in every state. In FLAGGED it shows 0 for flagged_player.

Optional Feature:
- Macro: DELAY_MODE_EN.
- Defined: for the first DELAY_S tick wraps of each turn, the active time is not decremented (simple/US delay). Decrementing starts at tick wrap DELAY_S+1. The delay counter restarts on start and on every move_done, and holds while PAUSED.
- Not defined: decrementing starts at the first tick wrap. The delay logic and counter are absent from the netlist.

Test Plan:
- CLK_FREQ_HZ=10, mode 0, start with first_player=0 -> time_left=60; 10 cycles later 59; disp_bcd=16'h0059 one cycle after that.
- Mode 1, player 0 plays 25 cycles (2 ticks) then move_done -> player 0 holds 180; active_player=1, time_left=180, tick counter 0.
- NUM_PLAYERS=3, three move_done pulses -> active_player sequence 0,1,2,0; mode 2 adds 3 s each turn.
- Mode 0, let 600 cycles elapse -> time_up=1, flagged_player=0, running=0; a later move_done has no effect; start -> RUN with 60.
- Tick wrap and move_done in the same cycle with time_left=1 -> FLAGGED, no rotation. Same case with time_left=5 -> 4+inc, rotate.
- pause high for 50 cycles mid-second -> time unchanged, resumes with the partial tick count kept. Reset asserted mid-RUN -> IDLE, outputs 0 immediately.
